// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that shares one clocked adder among
// NREQ requesters. It runs one operation at a time, waits the adder latency,
// and returns the sum tagged with the requester index.
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH:0]          add_sum,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH:0]          rsp_sum,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             busy_q, busy_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    int unsigned      scan_idx;

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[IDW'(scan_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
    end

    // One-hot accept to the granted requester, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    add_a_d  = req_a[gnt_idx*WIDTH +: WIDTH];
                    add_b_d  = req_b[gnt_idx*WIDTH +: WIDTH];
                    rsp_id_d = gnt_idx;
                    ptr_d    = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d    = CW'(ADD_LAT-1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_sum_d   = add_sum;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: one instance with ADD_LAT=1 and one with
// ADD_LAT=3, each paired with a behavioural adder of matching latency.
module tb_adder_arbiter;

    logic clk;
    logic rst;

    // ADD_LAT = 1 instance
    logic [3:0]  req_valid1, req_ready1;
    logic [63:0] req_a1, req_b1;
    logic [15:0] add_a1, add_b1;
    logic [16:0] add_sum1;
    logic        rsp_valid1, rsp_ready1, busy1;
    logic [16:0] rsp_sum1;
    logic [1:0]  rsp_id1;

    // ADD_LAT = 3 instance
    logic [3:0]  req_valid3, req_ready3;
    logic [63:0] req_a3, req_b3;
    logic [15:0] add_a3, add_b3;
    logic [16:0] add_sum3;
    logic        rsp_valid3, rsp_ready3, busy3;
    logic [16:0] rsp_sum3;
    logic [1:0]  rsp_id3;

    adder_arbiter #(.NREQ(4), .WIDTH(16), .ADD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1),
        .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_sum(rsp_sum1), .rsp_id(rsp_id1), .busy(busy1)
    );

    adder_arbiter #(.NREQ(4), .WIDTH(16), .ADD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_sum(rsp_sum3), .rsp_id(rsp_id3), .busy(busy3)
    );

    // Adder models: latency 1 is combinational from the held operands,
    // latency 3 has two register stages before the sampling edge.
    assign add_sum1 = 17'(add_a1) + 17'(add_b1);

    logic [16:0] pipe3_0, pipe3_1;
    always @(posedge clk) begin
        pipe3_0 <= 17'(add_a3) + 17'(add_b3);
        pipe3_1 <= pipe3_0;
    end
    assign add_sum3 = pipe3_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [16:0] sum;
    } exp_t;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    exp_t q1[$];
    exp_t q3[$];
    int   grant_ord[$];
    vec_t vecs[6];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Settle, score any response handshake that the coming edge completes,
    // then advance to the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (rsp_valid1 && rsp_ready1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL d1_unexpected_rsp: got id=%0d sum=%h, required no response", rsp_id1, rsp_sum1);
            end else begin
                e = q1.pop_front();
                check("d1_rsp_sum", 32'(rsp_sum1), 32'(e.sum));
                check("d1_rsp_id", 32'(rsp_id1), e.id);
            end
        end
        if (rsp_valid3 && rsp_ready3) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL d3_unexpected_rsp: got id=%0d sum=%h, required no response", rsp_id3, rsp_sum3);
            end else begin
                e = q3.pop_front();
                check("d3_rsp_sum", 32'(rsp_sum3), 32'(e.sum));
                check("d3_rsp_id", 32'(rsp_id3), e.id);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((q1.size() != 0 || q3.size() != 0) && budget < 40) begin
            step();
            budget++;
        end
        tests++;
        if (q1.size() + q3.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", q1.size() + q3.size());
        end
    endtask

    // Full single-operation timeline on the latency-1 instance
    task automatic single_op1(input int id, input logic [15:0] a, input logic [15:0] b,
                              input logic [16:0] sum);
        exp_t e;
        req_a1 = '0;
        req_b1 = '0;
        req_a1[id*16 +: 16] = a;
        req_b1[id*16 +: 16] = b;
        req_valid1 = 4'(1 << id);
        e.id  = id;
        e.sum = sum;
        q1.push_back(e);
        #1 check("d1_req_ready", 32'(req_ready1), 32'(1 << id));
        step();
        check("d1_wait_ready", 32'(req_ready1), 0);
        check("d1_busy_wait", 32'(busy1), 1);
        check("d1_rsp_early", 32'(rsp_valid1), 0);
        check("d1_add_a", 32'(add_a1), 32'(a));
        check("d1_add_b", 32'(add_b1), 32'(b));
        req_valid1 = '0;
        step();
        check("d1_rsp_valid", 32'(rsp_valid1), 1);
        step();
        check("d1_busy_idle", 32'(busy1), 0);
        check("d1_rsp_clear", 32'(rsp_valid1), 0);
    endtask

    // Observe accepts on the latency-1 instance against grant_ord, checking
    // the one-hot grant and the issue spacing; requests stay valid throughout.
    task automatic run_grants1();
        int got    = 0;
        int last   = 0;
        int budget = 0;
        int n      = grant_ord.size();
        while (got < n && budget < 60) begin
            #1;
            if (req_ready1 != '0) begin
                check("d1_grant", 32'(req_ready1), 32'(1 << grant_ord[got]));
                if (got > 0) check("d1_issue_gap", cyc - last, 3);
                last = cyc;
                got++;
            end
            step();
            budget++;
        end
        if (got < n) begin
            tests++; fails++;
            $display("FAIL d1_grant_timeout: got %0d grants, required %0d", got, n);
        end
        req_valid1 = '0;
        grant_ord.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] ra, rb;

        vecs[0] = '{2, 16'h0003, 16'h0004, 17'h00007};
        vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[2] = '{1, 16'h8000, 16'h8000, 17'h10000};
        vecs[3] = '{3, 16'h1234, 16'h4321, 17'h05555};
        vecs[4] = '{2, 16'hFFFF, 16'h0001, 17'h10000};
        vecs[5] = '{0, 16'h0000, 16'h0000, 17'h00000};

        rst = 1'b0;
        req_valid1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b1;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready1), 0);
        check("rst_add_a", 32'(add_a1), 0);
        check("rst_add_b", 32'(add_b1), 0);
        check("rst_rsp_valid", 32'(rsp_valid1), 0);
        check("rst_rsp_sum", 32'(rsp_sum1), 0);
        check("rst_rsp_id", 32'(rsp_id1), 0);
        check("rst_busy", 32'(busy1), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single operations, including carry-out cases
        for (int i = 0; i < 6; i++) begin
            single_op1(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum);
        end
        drain();

        // All four requesters valid from reset: grants 0,1,2,3,0
        pulse_reset();
        req_valid1 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ra = 16'h1111 * 16'(i + 1);
            rb = 16'h0F00 + 16'(i);
            req_a1[i*16 +: 16] = ra;
            req_b1[i*16 +: 16] = rb;
        end
        for (int k = 0; k < 5; k++) begin
            ra = 16'h1111 * 16'((k % 4) + 1);
            rb = 16'h0F00 + 16'(k % 4);
            e.id  = k % 4;
            e.sum = 17'(ra) + 17'(rb);
            q1.push_back(e);
            grant_ord.push_back(k % 4);
        end
        run_grants1();
        drain();

        // Fairness: grant 3 wraps ptr to 0, so 1 beats 3
        single_op1(3, 16'h00AA, 16'h0055, 17'h000FF);
        req_a1 = '0;
        req_b1 = '0;
        req_a1[1*16 +: 16] = 16'h0100; req_b1[1*16 +: 16] = 16'h0023;
        req_a1[3*16 +: 16] = 16'h7FFF; req_b1[3*16 +: 16] = 16'h0001;
        req_valid1 = 4'b1010;
        e.id = 1; e.sum = 17'h00123; q1.push_back(e);
        e.id = 3; e.sum = 17'h08000; q1.push_back(e);
        grant_ord.push_back(1);
        grant_ord.push_back(3);
        run_grants1();
        drain();

        // Backpressure on the latency-3 instance
        rsp_ready3 = 1'b0;
        req_a3 = '0;
        req_b3 = '0;
        req_a3[2*16 +: 16] = 16'hABCD;
        req_b3[2*16 +: 16] = 16'h6543;
        req_valid3 = 4'b0100;
        e.id = 2; e.sum = 17'h11110; q3.push_back(e);
        #1 check("d3_req_ready", 32'(req_ready3), 32'h4);
        for (int k = 0; k <= 3; k++) begin
            step();
            if (k == 0) begin
                req_valid3 = '0;
                check("d3_busy_wait", 32'(busy3), 1);
            end
            check("d3_rsp_latency", 32'(rsp_valid3), (k == 3) ? 1 : 0);
        end
        req_a3[0 +: 16] = 16'h0001;
        req_b3[0 +: 16] = 16'h0002;
        req_valid3 = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step();
            check("d3_hold_valid", 32'(rsp_valid3), 1);
            check("d3_hold_sum", 32'(rsp_sum3), 32'h11110);
            check("d3_hold_id", 32'(rsp_id3), 2);
            check("d3_hold_ready", 32'(req_ready3), 0);
        end
        rsp_ready3 = 1'b1;
        step();
        #1 check("d3_rearb_ready", 32'(req_ready3), 32'h1);
        req_valid3 = '0;
        #1 check("d3_withdraw_ready", 32'(req_ready3), 0);
        step();
        check("d3_withdraw_busy", 32'(busy3), 0);
        drain();

        // Reset while the latency-3 instance is in WAIT
        req_a3 = '0;
        req_b3 = '0;
        req_a3[1*16 +: 16] = 16'h5555;
        req_b3[1*16 +: 16] = 16'h1111;
        req_valid3 = 4'b0010;
        #1 check("d3_pre_rst_ready", 32'(req_ready3), 32'h2);
        step();
        check("d3_in_wait", 32'(busy3), 1);
        rst = 1'b1;
        #1;
        check("d3_rst_rsp_valid", 32'(rsp_valid3), 0);
        check("d3_rst_rsp_sum", 32'(rsp_sum3), 0);
        check("d3_rst_rsp_id", 32'(rsp_id3), 0);
        check("d3_rst_add_a", 32'(add_a3), 0);
        check("d3_rst_add_b", 32'(add_b3), 0);
        check("d3_rst_busy", 32'(busy3), 0);
        check("d3_rst_req_ready", 32'(req_ready3), 0);
        req_valid3 = '0;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("d3_no_rsp", 32'(rsp_valid3), 0);
        end
        req_a3[0 +: 16] = 16'h00F0;
        req_b3[0 +: 16] = 16'h000F;
        req_a3[1*16 +: 16] = 16'h0300;
        req_b3[1*16 +: 16] = 16'h0400;
        req_valid3 = 4'b0011;
        e.id = 0; e.sum = 17'h000FF; q3.push_back(e);
        #1 check("d3_post_rst_grant", 32'(req_ready3), 32'h1);
        step();
        req_valid3 = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
